// File: rtl/divider_flow_16by8b_pkg.sv
// Shared widths and constants for the pipelined restoring divider.
// The top and the stage module import this package for their default widths.
package divider_flow_16by8b_pkg;
  localparam int N_W_DEF = 16;
  localparam int D_W_DEF = 8;
  localparam logic [N_W_DEF-1:0] DIVZ_Q = '1;
endpackage

// File: rtl/divider_flow_16by8b_div_stage.sv
// One registered restoring-division step: resolves quotient bit N_W-K and
// carries the operands, partial remainder and partial quotient to the next stage.
module div_stage
  import divider_flow_16by8b_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF,
  parameter int K   = 1
) (
  input  logic           CP,
  input  logic           CLR,
  input  logic           CE,
  input  logic           vld_i,
  input  logic           divz_i,
  input  logic [N_W-1:0] dvd_i,
  input  logic [D_W-1:0] dvs_i,
  input  logic [D_W-1:0] rem_i,
  input  logic [N_W-1:0] quo_i,
  output logic           vld_o,
  output logic           divz_o,
  output logic [N_W-1:0] dvd_o,
  output logic [D_W-1:0] dvs_o,
  output logic [D_W-1:0] rem_o,
  output logic [N_W-1:0] quo_o
);
  localparam int BIT = N_W - K;

  logic [D_W:0]   rem_t;
  logic           qbit;
  logic [D_W-1:0] diff;

  logic           vld_d,  vld_q;
  logic           divz_d, divz_q;
  logic [N_W-1:0] dvd_d,  dvd_q;
  logic [D_W-1:0] dvs_d,  dvs_q;
  logic [D_W-1:0] rem_d,  rem_q;
  logic [N_W-1:0] quo_d,  quo_q;

  // The true difference is below the divisor whenever it is taken, so the
  // low D_W bits of the subtract are exact.
  always_comb begin
    rem_t  = {rem_i, dvd_i[BIT]};
    qbit   = (rem_t >= {1'b0, dvs_i});
    diff   = rem_t[D_W-1:0] - dvs_i;
    vld_d  = vld_i;
    divz_d = divz_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    if (vld_i) begin
      divz_d     = divz_i;
      dvd_d      = dvd_i;
      dvs_d      = dvs_i;
      rem_d      = qbit ? diff : rem_t[D_W-1:0];
      quo_d      = quo_i;
      quo_d[BIT] = qbit;
    end
  end

  always_ff @(posedge CP) begin
    if (CLR) begin
      vld_q  <= 1'b0;
      divz_q <= 1'b0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else if (CE) begin
      vld_q  <= vld_d;
      divz_q <= divz_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
    end
  end

  assign vld_o  = vld_q;
  assign divz_o = divz_q;
  assign dvd_o  = dvd_q;
  assign dvs_o  = dvs_q;
  assign rem_o  = rem_q;
  assign quo_o  = quo_q;
endmodule

// File: rtl/divider_flow_16by8b.sv
// Pipelined unsigned restoring divider: input register plus N_W single-bit
// stages, one result per enabled cycle, zero divisor flagged and forced.
module divider_flow_16by8b
  import divider_flow_16by8b_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF
) (
  input  logic           CP,
  input  logic           CLR,
  input  logic           CE,
  input  logic           IN_VLD,
  input  logic [N_W-1:0] A,
  input  logic [D_W-1:0] B,
  output logic           OUT_VLD,
  output logic [N_W-1:0] Q,
  output logic [D_W-1:0] R,
  output logic           DIVZ
);
  logic           vld_s  [0:N_W];
  logic           divz_s [0:N_W];
  logic [N_W-1:0] dvd_s  [0:N_W];
  logic [D_W-1:0] dvs_s  [0:N_W];
  logic [D_W-1:0] rem_s  [0:N_W];
  logic [N_W-1:0] quo_s  [0:N_W];

  logic           vld0_d,  vld0_q;
  logic           divz0_d, divz0_q;
  logic [N_W-1:0] dvd0_d,  dvd0_q;
  logic [D_W-1:0] dvs0_d,  dvs0_q;

  // Stage 0: input register; operands only load with a valid, bubbles keep the old data.
  always_comb begin
    vld0_d  = IN_VLD;
    divz0_d = divz0_q;
    dvd0_d  = dvd0_q;
    dvs0_d  = dvs0_q;
    if (IN_VLD) begin
      divz0_d = (B == '0);
      dvd0_d  = A;
      dvs0_d  = B;
    end
  end

  always_ff @(posedge CP) begin
    if (CLR) begin
      vld0_q  <= 1'b0;
      divz0_q <= 1'b0;
      dvd0_q  <= '0;
      dvs0_q  <= '0;
    end else if (CE) begin
      vld0_q  <= vld0_d;
      divz0_q <= divz0_d;
      dvd0_q  <= dvd0_d;
      dvs0_q  <= dvs0_d;
    end
  end

  assign vld_s[0]  = vld0_q;
  assign divz_s[0] = divz0_q;
  assign dvd_s[0]  = dvd0_q;
  assign dvs_s[0]  = dvs0_q;
  assign rem_s[0]  = '0;
  assign quo_s[0]  = '0;

  // Stages 1..N_W: quotient bit N_W-k resolved in stage k.
  for (genvar k = 1; k <= N_W; k++) begin : g_stage
    div_stage #(
      .N_W (N_W),
      .D_W (D_W),
      .K   (k)
    ) u_stage (
      .CP     (CP),
      .CLR    (CLR),
      .CE     (CE),
      .vld_i  (vld_s[k-1]),
      .divz_i (divz_s[k-1]),
      .dvd_i  (dvd_s[k-1]),
      .dvs_i  (dvs_s[k-1]),
      .rem_i  (rem_s[k-1]),
      .quo_i  (quo_s[k-1]),
      .vld_o  (vld_s[k]),
      .divz_o (divz_s[k]),
      .dvd_o  (dvd_s[k]),
      .dvs_o  (dvs_s[k]),
      .rem_o  (rem_s[k]),
      .quo_o  (quo_s[k])
    );
  end

  // Output stage: a zero divisor overrides the arithmetic result.
  assign OUT_VLD = vld_s[N_W];
  assign DIVZ    = divz_s[N_W];
  assign Q       = divz_s[N_W] ? '1 : quo_s[N_W];
  assign R       = divz_s[N_W] ? '0 : rem_s[N_W];
endmodule
